// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single-port data SRAM between the instruction
// decoder (CPU port, read/write) and the LCD driver (LCD port, read-only).
// Accesses are serialised through IDLE -> ACCESS -> [WAIT x RD_LAT] -> DONE
// with a req/gnt/done handshake on each port.
// Default build: round-robin between the two ports on contention.
// Optional macro SRAM_ARB_CPU_PRIO_EN: the CPU wins contention, and an LCD
// starvation guard hands the SRAM to the LCD after 16 consecutive CPU wins.
module sram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              lcd_req,
    input  logic [ADDR_W-1:0] lcd_addr,
    output logic              lcd_gnt,
    output logic              lcd_done,
    output logic [DATA_W-1:0] lcd_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     state;
    logic       win_lcd;       // latched winner: 1 = LCD, 0 = CPU
    logic       we_l;          // latched write flag of the winner
    logic       rr_last_lcd;   // 1 = LCD was served last
    logic [2:0] wait_cnt;
    logic       pick_lcd;

    // The last WAIT cycle is the one in which the SRAM presents read data.
    localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

`ifdef SRAM_ARB_CPU_PRIO_EN
    logic [7:0] starve_cnt;
`endif

    // Winner selection for the current IDLE cycle.
    always_comb begin
        pick_lcd = 1'b0;
        if (lcd_req && !cpu_req) begin
            pick_lcd = 1'b1;
        end else if (lcd_req && cpu_req) begin
`ifdef SRAM_ARB_CPU_PRIO_EN
            pick_lcd = (starve_cnt >= 8'd16);
`else
            pick_lcd = !rr_last_lcd;
`endif
        end
    end

    // Transaction FSM with registered handshake and SRAM strobe outputs.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            win_lcd     <= 1'b0;
            we_l        <= 1'b0;
            rr_last_lcd <= 1'b1;
            wait_cnt    <= 3'd0;
            cpu_gnt     <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_rdata   <= '0;
            lcd_gnt     <= 1'b0;
            lcd_done    <= 1'b0;
            lcd_rdata   <= '0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
`ifdef SRAM_ARB_CPU_PRIO_EN
            starve_cnt  <= 8'd0;
`endif
        end else begin
            cpu_done <= 1'b0;
            lcd_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req || lcd_req) begin
                        // mem_addr/mem_wdata double as the latched request,
                        // so later requester input changes are ignored.
                        win_lcd   <= pick_lcd;
                        we_l      <= !pick_lcd && cpu_we;
                        mem_addr  <= pick_lcd ? lcd_addr : cpu_addr;
                        mem_wr_en <= !pick_lcd && cpu_we;
                        mem_rd_en <= pick_lcd || !cpu_we;
                        mem_wdata <= (!pick_lcd && cpu_we) ? cpu_wdata : '0;
                        cpu_gnt   <= !pick_lcd;
                        lcd_gnt   <= pick_lcd;
                        busy      <= 1'b1;
                        state     <= S_ACCESS;
`ifdef SRAM_ARB_CPU_PRIO_EN
                        if (pick_lcd) begin
                            starve_cnt <= 8'd0;
                        end else if (lcd_req) begin
                            starve_cnt <= starve_cnt + 8'd1;
                        end
`endif
                    end
                end
                S_ACCESS: begin
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                    wait_cnt  <= 3'd0;
                    if (we_l) begin
                        cpu_done <= !win_lcd;
                        lcd_done <= win_lcd;
                        state    <= S_DONE;
                    end else begin
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (win_lcd) begin
                            lcd_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                        cpu_done <= !win_lcd;
                        lcd_done <= win_lcd;
                        wait_cnt <= 3'd0;
                        state    <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    cpu_gnt     <= 1'b0;
                    lcd_gnt     <= 1'b0;
                    busy        <= 1'b0;
                    rr_last_lcd <= win_lcd;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter with a
// behavioural SRAM (read latency 1, initial content mem[a] = a ^ 8'h5A).
module tb_sram_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;
    logic              lcd_req = 1'b0;
    logic [ADDR_W-1:0] lcd_addr = '0;
    logic              lcd_gnt;
    logic              lcd_done;
    logic [DATA_W-1:0] lcd_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              busy;

    int tests = 0;
    int fails = 0;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .lcd_req(lcd_req), .lcd_addr(lcd_addr),
        .lcd_gnt(lcd_gnt), .lcd_done(lcd_done), .lcd_rdata(lcd_rdata),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM, loaded with a known pattern on the first edge.
    logic [DATA_W-1:0] mem [0:255];
    logic              mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_loaded <= 1'b1;
        end else begin
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= mem[mem_addr];
        end
    end

    // Continuous exclusivity check: one grant at a time, no LCD write, one strobe.
    always @(negedge clk) begin
        if (!sys_rst) begin
            tests++;
            if ((cpu_gnt && lcd_gnt) || (lcd_gnt && mem_wr_en) || (mem_rd_en && mem_wr_en)) begin
                fails++;
                $display("FAIL exclusive @%0t: cpu_gnt=%b lcd_gnt=%b rd=%b wr=%b, required no overlap",
                         $time, cpu_gnt, lcd_gnt, mem_rd_en, mem_wr_en);
            end
        end
    end

    task automatic check_all_zero(input string nm);
        tests++;
        if ({cpu_gnt, cpu_done, cpu_rdata, lcd_gnt, lcd_done, lcd_rdata, mem_addr,
             mem_rd_en, mem_wr_en, mem_wdata, busy} !== '0) begin
            fails++;
            $display("FAIL %s: gnt=%b/%b done=%b/%b rdata=%h/%h addr=%h rd=%b wr=%b wdata=%h busy=%b, required all 0",
                     nm, cpu_gnt, lcd_gnt, cpu_done, lcd_done, cpu_rdata, lcd_rdata,
                     mem_addr, mem_rd_en, mem_wr_en, mem_wdata, busy);
        end
    endtask

    // One CPU transaction; req raised at a negedge while the arbiter is IDLE.
    task automatic cpu_xfer(input logic we, input logic [7:0] a, input logic [7:0] d,
                            input int exp_lat, input string nm);
        int lat = 0;
        int nstb = 0;
        logic [7:0] sa = '0;
        logic [7:0] sd = '0;
        logic lg = 1'b0;
        logic wrong = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lcd_gnt) lg = 1'b1;
            if (we ? mem_wr_en : mem_rd_en) begin nstb++; sa = mem_addr; sd = mem_wdata; end
            if (we ? mem_rd_en : mem_wr_en) wrong = 1'b1;
            if (cpu_done) break;
        end
        cpu_req = 1'b0;
        tests++;
        if (lat !== exp_lat) begin fails++; $display("FAIL %s latency: got %0d, required %0d", nm, lat, exp_lat); end
        tests++;
        if (nstb !== 1) begin fails++; $display("FAIL %s strobe count: got %0d, required 1", nm, nstb); end
        tests++;
        if (sa !== a) begin fails++; $display("FAIL %s mem_addr: got %h, required %h", nm, sa, a); end
        tests++;
        if (sd !== (we ? d : 8'h00)) begin fails++; $display("FAIL %s mem_wdata: got %h, required %h", nm, sd, we ? d : 8'h00); end
        tests++;
        if (lg !== 1'b0) begin fails++; $display("FAIL %s lcd_gnt: got 1, required 0", nm); end
        tests++;
        if (wrong !== 1'b0) begin fails++; $display("FAIL %s wrong strobe: got 1, required 0", nm); end
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        sys_rst = 1'b0;
    endtask

    task automatic test_write;
        cpu_xfer(1'b1, 8'h10, 8'hA5, 2, "cpu_write");
        @(negedge clk);
        tests++;
        if ({cpu_done, cpu_gnt, busy} !== 3'b000) begin
            fails++;
            $display("FAIL write_after_done: done/gnt/busy=%b, required 000", {cpu_done, cpu_gnt, busy});
        end
    endtask

    task automatic test_read_hold;
        cpu_xfer(1'b0, 8'h10, 8'h00, 2 + RD_LAT, "cpu_read");
        tests++;
        if (cpu_rdata !== 8'hA5) begin fails++; $display("FAIL read_data: got %h, required a5", cpu_rdata); end
        for (int i = 0; i < 3; i++) begin
            cpu_xfer(1'b1, 8'(8'h11 + i), 8'(8'hC0 + i), 2, "cpu_write_hold");
            tests++;
            if (cpu_rdata !== 8'hA5) begin fails++; $display("FAIL rdata_hold%0d: got %h, required a5", i, cpu_rdata); end
        end
    endtask

    task automatic test_round_robin;
        int got [4];
        int exp [4];
        int n = 0;
        int cyc = 0;
`ifdef SRAM_ARB_CPU_PRIO_EN
        exp = '{0, 0, 0, 0};
`else
        exp = '{0, 1, 0, 1};
`endif
        got = '{-1, -1, -1, -1};
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
        lcd_req = 1'b1; lcd_addr = 8'h40;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cpu_done) begin
                got[n] = 0; n++;
                tests++;
                if (cpu_rdata !== 8'h6A) begin fails++; $display("FAIL rr_cpu_rdata: got %h, required 6a", cpu_rdata); end
            end else if (lcd_done) begin
                got[n] = 1; n++;
                tests++;
                if (lcd_rdata !== 8'h1A) begin fails++; $display("FAIL rr_lcd_rdata: got %h, required 1a", lcd_rdata); end
            end
        end
        cpu_req = 1'b0; lcd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL rr_order[%0d]: got %0d, required %0d (0=cpu 1=lcd)", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_lcd_then_cpu;
        int k = 0;
        int stb = 0;
        @(negedge clk);
        lcd_req = 1'b1; lcd_addr = 8'h20;
        @(negedge clk);
        tests++;
        if ({lcd_gnt, mem_rd_en, mem_addr} !== {1'b1, 1'b1, 8'h20}) begin
            fails++;
            $display("FAIL lcd_access: gnt=%b rd=%b addr=%h, required 1 1 20", lcd_gnt, mem_rd_en, mem_addr);
        end
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h21;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (mem_rd_en || mem_wr_en) stb++;
            if (lcd_done) break;
        end
        lcd_req = 1'b0;
        tests++;
        if (k !== RD_LAT) begin fails++; $display("FAIL lcd_done_timing: got %0d, required %0d", k, RD_LAT); end
        tests++;
        if (stb !== 0) begin fails++; $display("FAIL strobe_before_lcd_done: got %0d, required 0", stb); end
        tests++;
        if (lcd_rdata !== 8'h7A) begin fails++; $display("FAIL lcd_rdata: got %h, required 7a", lcd_rdata); end
        @(negedge clk);
        tests++;
        if ({cpu_gnt, mem_rd_en} !== 2'b00) begin
            fails++;
            $display("FAIL idle_gap: cpu_gnt/rd=%b, required 00", {cpu_gnt, mem_rd_en});
        end
        @(negedge clk);
        tests++;
        if ({cpu_gnt, mem_rd_en, mem_addr} !== {1'b1, 1'b1, 8'h21}) begin
            fails++;
            $display("FAIL cpu_access_after_lcd: gnt=%b rd=%b addr=%h, required 1 1 21", cpu_gnt, mem_rd_en, mem_addr);
        end
        k = 0;
        while (k < 20 && !cpu_done) begin
            @(negedge clk);
            k++;
        end
        cpu_req = 1'b0;
        tests++;
        if (cpu_rdata !== 8'h7B) begin fails++; $display("FAIL cpu_rdata_after_lcd: got %h, required 7b", cpu_rdata); end
    endtask

    task automatic test_reset_mid;
        logic seen_done = 1'b0;
        int first = -1;
        int k = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h22;
        @(negedge clk);
        @(negedge clk);
        #1 sys_rst = 1'b1;
        #1 check_all_zero("reset_mid_wait");
        cpu_req = 1'b0;
        @(negedge clk);
        sys_rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_done || lcd_done) seen_done = 1'b1;
        end
        tests++;
        if (seen_done !== 1'b0) begin fails++; $display("FAIL done_after_reset: got 1, required 0"); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h31;
        lcd_req = 1'b1; lcd_addr = 8'h41;
        while (k < 20 && first < 0) begin
            @(negedge clk);
            k++;
            if (cpu_done) first = 0;
            else if (lcd_done) first = 1;
        end
        cpu_req = 1'b0; lcd_req = 1'b0;
        tests++;
        if (first !== 0) begin fails++; $display("FAIL first_after_reset: got %0d, required 0 (cpu)", first); end
    endtask

    task automatic test_starvation;
        int cpu_wins = 0;
        int lcd_wins = 0;
        int cyc = 0;
        int exp_cpu;
`ifdef SRAM_ARB_CPU_PRIO_EN
        exp_cpu = 16;
`else
        exp_cpu = 1;
`endif
        @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h33;
        lcd_req = 1'b1; lcd_addr = 8'h40;
        while (cyc < 400 && lcd_wins == 0) begin
            @(negedge clk);
            cyc++;
            if (cpu_done) cpu_wins++;
            if (lcd_done) lcd_wins++;
        end
        cpu_req = 1'b0; lcd_req = 1'b0;
        tests++;
        if (lcd_wins !== 1) begin fails++; $display("FAIL lcd_granted: got %0d, required 1", lcd_wins); end
        tests++;
        if (cpu_wins !== exp_cpu) begin fails++; $display("FAIL cpu_wins_before_lcd: got %0d, required %0d", cpu_wins, exp_cpu); end
        tests++;
        if (lcd_rdata !== 8'h1A) begin fails++; $display("FAIL starve_lcd_rdata: got %h, required 1a", lcd_rdata); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_hold();
        test_round_robin();
        test_lcd_then_cpu();
        test_reset_mid();
        test_starvation();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port data SRAM between two requesters: the instruction decoder (CPU port, read/write) and the LCD driver (LCD port, read-only fetch of print data).
- Serialises accesses with a req/gnt/done handshake and round-robin arbitration.
- Drives dedicated, unidirectional SRAM strobes, address and write data, so no requester drives the SRAM data bus directly.
- Sits between the decoder, the LCD driver and the SRAM macro.

Parameters:
ADDR_W, 8, SRAM address width
DATA_W, 8, SRAM data width
RD_LAT, 1, cycles from mem_rd_en high to mem_rdata valid; legal range 1..7

Ports:
clk  in  1  system clock
sys_rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  CPU access request; addr, we and wdata held stable while high
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU transaction in progress
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  CPU read data, registered
lcd_req  in  1  LCD read request; addr held stable while high
lcd_addr  in  ADDR_W  LCD read address
lcd_gnt  out  1  LCD transaction in progress
lcd_done  out  1  one-cycle completion pulse
lcd_rdata  out  DATA_W  LCD read data, registered
mem_addr  out  ADDR_W  SRAM address
mem_rd_en  out  1  SRAM read strobe
mem_wr_en  out  1  SRAM write strobe
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0; rr_last = LCD, so the CPU wins the first contention.
- State IDLE:
  - Samples cpu_req and lcd_req.
  - One request pending: that port wins.
  - Both pending: the port not equal to rr_last wins.
  - Winner port, address, we and wdata are latched into internal registers, so later changes on the requester inputs are ignored.
  - Next state: ACCESS.
- State ACCESS (exactly 1 cycle):
  - mem_addr = latched address; mem_rd_en = !we or mem_wr_en = we, high for this single cycle only.
  - mem_wdata = latched wdata on writes, 0 on reads.
  - Winner's gnt goes high here.
  - Next state: write -> DONE; read -> WAIT.
- State WAIT:
  - Counts RD_LAT cycles; mem_addr holds its value and both strobes stay low.
  - On the last WAIT cycle, mem_rdata is captured into the winner's rdata register.
  - Next state: DONE.
- State DONE (1 cycle):
  - Winner's done = 1 and gnt = 1; rdata is valid for a read.
  - rr_last = winner.
  - Next state: IDLE.
- gnt is high from ACCESS through DONE inclusive and low otherwise; never both gnt high at once.
- Latency, request first seen in IDLE at cycle t:
  - Write: strobe at t+1, done at t+2.
  - Read: strobe at t+1, done at t+2+RD_LAT.
- Back-to-back issue:
  - Minimum IDLE gap between transactions is 1 cycle.
  - A req still high in the IDLE cycle after its done is treated as a new request.
  - Requesters drop req in the cycle after done to avoid a repeat access.
- Early drop: req deasserted mid-transaction does not abort it; the access completes and done still pulses.
- Read data hold: rdata of each port holds until that port's next completed read. Writes leave rdata unchanged.
- The LCD port is read-only: no write strobe is ever issued for an LCD grant.
- Reset mid-operation, asynchronous:
  - Strobes, gnt and done go low immediately; state returns to IDLE and rr_last to LCD.
  - Any in-flight write may or may not have reached the SRAM.
  - No done is issued for the interrupted transaction.

Optional Feature:
- Macro SRAM_ARB_CPU_PRIO_EN.
- Defined: fixed priority. The CPU always wins contention and rr_last is ignored. An LCD starvation guard applies:
  - An 8-bit counter increments in each IDLE cycle in which lcd_req is high and the CPU wins.
  - When the counter reaches 8'd16, the LCD wins the next contention.
  - The counter clears whenever the LCD is granted.
- Undefined: round-robin as above; the counter logic is absent.

Test Plan:
- Reset, then CPU write addr 0x10 data 0xA5 -> mem_wr_en high for exactly 1 cycle with mem_addr 0x10 and mem_wdata 0xA5; cpu_done 2 cycles after req first sampled; lcd_gnt stays 0.
- Following CPU read of 0x10 with SRAM model RD_LAT=1 -> mem_rd_en 1 cycle; cpu_done at t+3; cpu_rdata = 0xA5 and held through 3 later CPU writes.
- cpu_req and lcd_req raised in the same cycle after reset, both reads -> CPU granted first. Both held high again after done -> LCD granted next; alternation CPU, LCD, CPU, LCD over 4 transactions.
- LCD read of 0x20, with cpu_req rising during the LCD's WAIT -> no strobe until lcd_done; CPU ACCESS starts 2 cycles after lcd_done; lcd_rdata equals the SRAM content at 0x20.
- sys_rst asserted in a read's WAIT cycle -> all outputs 0 within the reset cycle, no done pulse; the first contention after release goes to the CPU.
- With SRAM_ARB_CPU_PRIO_EN: lcd_req held high while the CPU issues continuous requests -> LCD granted exactly once after 16 CPU wins; without the macro, the LCD is granted on the 2nd transaction.
